// File: rtl/prf_ram_partitioned_pg_if.sv
// Port bundle for the partitioned physical register file: read, write, lane-gating and power-request signals.
// The master side drives addresses, write data and requests; the slave side (the register file) returns data and status.
interface prf_ram_partitioned_pg_if #(
  parameter int RPORT     = 8,
  parameter int WPORT     = 4,
  parameter int INDEX     = 7,
  parameter int WIDTH     = 64,
  parameter int NUM_PARTS = 4
) ();
  logic [RPORT*INDEX-1:0] rdAddr_i;
  logic [RPORT*WIDTH-1:0] rdData_o;
  logic [RPORT-1:0]       rdValid_o;
  logic [WPORT*INDEX-1:0] wrAddr_i;
  logic [WPORT*WIDTH-1:0] wrData_i;
  logic [WPORT-1:0]       we_i;
  logic [WPORT-1:0]       execLaneActive_i;
  logic [NUM_PARTS-1:0]   rfPartitionActive_i;
  logic [NUM_PARTS-1:0]   partReady_o;
  logic                   wrDropped_o;

  modport master (
    output rdAddr_i, wrAddr_i, wrData_i, we_i, execLaneActive_i, rfPartitionActive_i,
    input  rdData_o, rdValid_o, partReady_o, wrDropped_o
  );

  modport slave (
    input  rdAddr_i, wrAddr_i, wrData_i, we_i, execLaneActive_i, rfPartitionActive_i,
    output rdData_o, rdValid_o, partReady_o, wrDropped_o
  );
endinterface

// File: rtl/prf_ram_partitioned_pg.sv
// Partitioned PRF with per-partition OFF/ACTIVE power control, registered 1-cycle reads with write bypass.
// PRF_SCRUB_EN: adds a SCRUB state that zeroes every row of a partition before it reports ready.
module prf_ram_partitioned_pg #(
  parameter int RPORT         = 8,
  parameter int WPORT         = 4,
  parameter int DEPTH         = 128,
  parameter int INDEX         = 7,
  parameter int WIDTH         = 64,
  parameter int NUM_PARTS     = 4,
  parameter int NUM_PARTS_LOG = 2
) (
  input logic                    clk,
  input logic                    reset,
  prf_ram_partitioned_pg_if.slave bus
);

  localparam int ROW_W = INDEX - NUM_PARTS_LOG;

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
`ifdef PRF_SCRUB_EN
  localparam int         ROWS      = DEPTH / NUM_PARTS;
  localparam logic [1:0] ST_SCRUB  = 2'd1;
`endif

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [1:0]             r_state [NUM_PARTS];
`ifdef PRF_SCRUB_EN
  logic [ROW_W-1:0]       r_scrub_cnt [NUM_PARTS];
`endif
  logic [RPORT*WIDTH-1:0] r_rd_data;
  logic [RPORT-1:0]       r_rd_vld;
  logic                   r_wr_dropped;

  logic [NUM_PARTS-1:0]   w_part_act;
  logic [WPORT-1:0]       w_wr_req;
  logic [WPORT-1:0]       w_commit;
  logic                   w_drop;
  logic [RPORT*WIDTH-1:0] w_rd_data;
  logic [RPORT-1:0]       w_rd_vld;

  // With a single partition the shift clears every bit, so partition 0 falls out naturally.
  function automatic int part_of(input logic [INDEX-1:0] a);
    return int'(a >> ROW_W);
  endfunction

  function automatic logic part_hit(input logic [INDEX-1:0] a, input logic [NUM_PARTS-1:0] act);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_PARTS; k++) begin
      if (part_of(a) == k) hit = act[k];
    end
    return hit;
  endfunction

  always_comb begin
    w_part_act = '0;
    for (int k = 0; k < NUM_PARTS; k++) begin
      w_part_act[k] = (r_state[k] == ST_ACTIVE);
    end
  end

  always_comb begin
    w_wr_req = '0;
    w_commit = '0;
    for (int w = 0; w < WPORT; w++) begin
      w_wr_req[w] = bus.we_i[w] & bus.execLaneActive_i[w];
      w_commit[w] = w_wr_req[w] & part_hit(bus.wrAddr_i[w*INDEX +: INDEX], w_part_act);
    end
  end

  assign w_drop = |(w_wr_req & ~w_commit);

  always_comb begin
    logic [INDEX-1:0] ra;
    logic [WIDTH-1:0] rd;
    w_rd_data = '0;
    w_rd_vld  = '0;
    ra        = '0;
    rd        = '0;
    for (int p = 0; p < RPORT; p++) begin
      ra = bus.rdAddr_i[p*INDEX +: INDEX];
      rd = '0;
      if (bus.execLaneActive_i[p/2] && part_hit(ra, w_part_act)) begin
        rd = r_mem[ra];
        // Ascending scan lets the highest-numbered committing port win the bypass.
        for (int w = 0; w < WPORT; w++) begin
          if (w_commit[w] && (bus.wrAddr_i[w*INDEX +: INDEX] == ra)) begin
            rd = bus.wrData_i[w*WIDTH +: WIDTH];
          end
        end
        w_rd_vld[p] = 1'b1;
      end
      w_rd_data[p*WIDTH +: WIDTH] = rd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_PARTS; k++) begin
        r_state[k] <= ST_OFF;
`ifdef PRF_SCRUB_EN
        r_scrub_cnt[k] <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < NUM_PARTS; k++) begin
        case (r_state[k])
`ifdef PRF_SCRUB_EN
          ST_OFF: begin
            r_scrub_cnt[k] <= '0;
            if (bus.rfPartitionActive_i[k]) r_state[k] <= ST_SCRUB;
          end
          ST_SCRUB: begin
            if (!bus.rfPartitionActive_i[k]) begin
              r_state[k]     <= ST_OFF;
              r_scrub_cnt[k] <= '0;
            end else if (r_scrub_cnt[k] == ROW_W'(ROWS - 1)) begin
              r_state[k]     <= ST_ACTIVE;
              r_scrub_cnt[k] <= '0;
            end else begin
              r_scrub_cnt[k] <= r_scrub_cnt[k] + ROW_W'(1);
            end
          end
`else
          ST_OFF: begin
            if (bus.rfPartitionActive_i[k]) r_state[k] <= ST_ACTIVE;
          end
`endif
          ST_ACTIVE: begin
            if (!bus.rfPartitionActive_i[k]) r_state[k] <= ST_OFF;
          end
          default: r_state[k] <= ST_OFF;
        endcase
      end
    end
  end

  // Array has no reset; scrub and user writes never target the same partition in one cycle.
  always_ff @(posedge clk) begin
`ifdef PRF_SCRUB_EN
    for (int k = 0; k < NUM_PARTS; k++) begin
      if (r_state[k] == ST_SCRUB) begin
        r_mem[INDEX'(k * ROWS) | INDEX'(r_scrub_cnt[k])] <= '0;
      end
    end
`endif
    for (int w = 0; w < WPORT; w++) begin
      if (w_commit[w]) r_mem[bus.wrAddr_i[w*INDEX +: INDEX]] <= bus.wrData_i[w*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data    <= '0;
      r_rd_vld     <= '0;
      r_wr_dropped <= 1'b0;
    end else begin
      r_rd_data    <= w_rd_data;
      r_rd_vld     <= w_rd_vld;
      r_wr_dropped <= w_drop;
    end
  end

  assign bus.rdData_o    = r_rd_data;
  assign bus.rdValid_o   = r_rd_vld;
  assign bus.partReady_o = w_part_act;
  assign bus.wrDropped_o = r_wr_dropped;

endmodule

// File: tb/tb_prf_ram_partitioned_pg.sv
// Directed bench for prf_ram_partitioned_pg: power sequencing, write priority, bypass, drops, lane gating, async reset.
// Expected ready latency depends on whether PRF_SCRUB_EN is defined.
module tb_prf_ram_partitioned_pg;
  localparam int RPORT = 8, WPORT = 4, DEPTH = 128, INDEX = 7, WIDTH = 64, NUM_PARTS = 4, NUM_PARTS_LOG = 2;
`ifdef PRF_SCRUB_EN
  localparam int READY_LAT = 33;
`else
  localparam int READY_LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  prf_ram_partitioned_pg_if #(.RPORT(RPORT), .WPORT(WPORT), .INDEX(INDEX), .WIDTH(WIDTH),
                              .NUM_PARTS(NUM_PARTS)) bus ();

  prf_ram_partitioned_pg #(.RPORT(RPORT), .WPORT(WPORT), .DEPTH(DEPTH), .INDEX(INDEX), .WIDTH(WIDTH),
                           .NUM_PARTS(NUM_PARTS), .NUM_PARTS_LOG(NUM_PARTS_LOG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input logic [INDEX-1:0] a);
    bus.rdAddr_i[p*INDEX +: INDEX] = a;
  endtask

  task automatic set_wr(input int w, input logic [INDEX-1:0] a, input logic [WIDTH-1:0] d);
    bus.wrAddr_i[w*INDEX +: INDEX] = a;
    bus.wrData_i[w*WIDTH +: WIDTH] = d;
    bus.we_i[w] = 1'b1;
  endtask

  function automatic logic [WIDTH-1:0] rd_data(input int p);
    return bus.rdData_o[p*WIDTH +: WIDTH];
  endfunction

  task automatic wait_ready(input int k, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.partReady_o[k] && n < 200);
  endtask

  task automatic test_reset();
    bus.rdAddr_i = '0;
    bus.wrAddr_i = '0;
    bus.wrData_i = '0;
    bus.we_i = '0;
    bus.execLaneActive_i = 4'b1111;
    bus.rfPartitionActive_i = 4'b0001;
    #1 reset = 1'b0;
    tick();
    tick();
    checks++; if (bus.partReady_o !== 4'b0000) begin errors++; $display("FAIL rst_ready got %b exp 0000", bus.partReady_o); end
    checks++; if (bus.rdValid_o !== 8'h00) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.rdValid_o); end
    checks++; if (bus.rdData_o !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", bus.rdData_o); end
    checks++; if (bus.wrDropped_o !== 1'b0) begin errors++; $display("FAIL rst_drop got %b exp 0", bus.wrDropped_o); end
  endtask

  task automatic test_power_up();
    int n;
    reset = 1'b1;
    wait_ready(0, n);
    checks++; if (n !== READY_LAT) begin errors++; $display("FAIL up_latency got %0d exp %0d", n, READY_LAT); end
    set_rd(0, 7'd5);
`ifndef PRF_SCRUB_EN
    set_wr(0, 7'd5, 64'd0);
`endif
    tick();
    bus.we_i = '0;
    checks++; if (rd_data(0) !== 64'd0) begin errors++; $display("FAIL up_read5_data got %h exp 0", rd_data(0)); end
    checks++; if (bus.rdValid_o[0] !== 1'b1) begin errors++; $display("FAIL up_read5_valid got %b exp 1", bus.rdValid_o[0]); end
  endtask

  task automatic test_write_priority();
    set_wr(0, 7'd3, 64'hDEAD);
    set_wr(3, 7'd3, 64'hBEEF);
    set_rd(1, 7'd3);
    tick();
    bus.we_i = '0;
    checks++; if (rd_data(1) !== 64'hBEEF) begin errors++; $display("FAIL prio_bypass got %h exp BEEF", rd_data(1)); end
    checks++; if (bus.rdValid_o[1] !== 1'b1) begin errors++; $display("FAIL prio_valid got %b exp 1", bus.rdValid_o[1]); end
    tick();
    checks++; if (rd_data(1) !== 64'hBEEF) begin errors++; $display("FAIL prio_array got %h exp BEEF", rd_data(1)); end
  endtask

  task automatic test_drop();
    set_wr(1, 7'h45, 64'h1234);
    set_rd(2, 7'h45);
    tick();
    bus.we_i = '0;
    checks++; if (bus.wrDropped_o !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b exp 1", bus.wrDropped_o); end
    checks++; if (bus.rdValid_o[2] !== 1'b0) begin errors++; $display("FAIL drop_rd_valid got %b exp 0", bus.rdValid_o[2]); end
    checks++; if (rd_data(2) !== 64'd0) begin errors++; $display("FAIL drop_rd_data got %h exp 0", rd_data(2)); end
    tick();
    checks++; if (bus.wrDropped_o !== 1'b0) begin errors++; $display("FAIL drop_single got %b exp 0", bus.wrDropped_o); end
  endtask

  task automatic test_lane_gate();
    set_wr(0, 7'd7, 64'h11);
    tick();
    bus.we_i = '0;
    bus.execLaneActive_i = 4'b0111;
    set_wr(3, 7'd7, 64'h77);
    set_rd(6, 7'd3);
    set_rd(7, 7'd3);
    tick();
    bus.we_i = '0;
    checks++; if (bus.wrDropped_o !== 1'b0) begin errors++; $display("FAIL gate_drop got %b exp 0", bus.wrDropped_o); end
    checks++; if (bus.rdValid_o[7:6] !== 2'b00) begin errors++; $display("FAIL gate_valid got %b exp 00", bus.rdValid_o[7:6]); end
    checks++; if (rd_data(6) !== 64'd0 || rd_data(7) !== 64'd0) begin
      errors++; $display("FAIL gate_data got %h %h exp 0 0", rd_data(6), rd_data(7));
    end
    bus.execLaneActive_i = 4'b1111;
    set_rd(0, 7'd7);
    tick();
    checks++; if (rd_data(0) !== 64'h11) begin errors++; $display("FAIL gate_nowrite got %h exp 11", rd_data(0)); end
  endtask

  task automatic test_scrub_abort();
    int n;
    bus.rfPartitionActive_i[1] = 1'b1;
    wait_ready(1, n);
    checks++; if (n !== READY_LAT) begin errors++; $display("FAIL p1_first_latency got %0d exp %0d", n, READY_LAT); end
    set_wr(0, 7'd40, 64'hAA);
    tick();
    bus.we_i = '0;
    bus.rfPartitionActive_i[1] = 1'b0;
    tick();
    checks++; if (bus.partReady_o[1] !== 1'b0) begin errors++; $display("FAIL p1_off got %b exp 0", bus.partReady_o[1]); end
`ifdef PRF_SCRUB_EN
    bus.rfPartitionActive_i[1] = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    bus.rfPartitionActive_i[1] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    bus.rfPartitionActive_i[1] = 1'b1;
    wait_ready(1, n);
    checks++; if (n !== 33) begin errors++; $display("FAIL p1_restart_latency got %0d exp 33", n); end
    for (int r = 0; r < 4; r++) begin
      for (int p = 0; p < RPORT; p++) set_rd(p, 7'(32 + r*8 + p));
      tick();
      for (int p = 0; p < RPORT; p++) begin
        checks++;
        if (rd_data(p) !== 64'd0 || bus.rdValid_o[p] !== 1'b1) begin
          errors++; $display("FAIL p1_row%0d got %h/%b exp 0/1", r*8 + p, rd_data(p), bus.rdValid_o[p]);
        end
      end
    end
`else
    bus.rfPartitionActive_i[1] = 1'b1;
    wait_ready(1, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL p1_rewake_latency got %0d exp 1", n); end
    set_rd(0, 7'd40);
    tick();
    checks++; if (rd_data(0) !== 64'hAA) begin errors++; $display("FAIL p1_retain got %h exp AA", rd_data(0)); end
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    bus.rfPartitionActive_i[2] = 1'b1;
    set_rd(0, 7'd3);
    for (int i = 0; i < 6; i++) tick();
    checks++; if (bus.rdValid_o[0] !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", bus.rdValid_o[0]); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.partReady_o !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b exp 0000", bus.partReady_o); end
    checks++; if (bus.rdValid_o !== 8'h00 || bus.rdData_o !== '0) begin
      errors++; $display("FAIL mid_rd got %b %h exp 0 0", bus.rdValid_o, bus.rdData_o);
    end
    bus.rfPartitionActive_i = 4'b0100;
    tick();
    reset = 1'b1;
    wait_ready(2, n);
    checks++; if (n !== READY_LAT) begin errors++; $display("FAIL mid_restart_latency got %0d exp %0d", n, READY_LAT); end
    checks++; if (bus.partReady_o !== 4'b0100) begin errors++; $display("FAIL mid_ready_after got %b exp 0100", bus.partReady_o); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_write_priority();
    test_drop();
    test_lane_gate();
    test_scrub_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
